// File: rtl/hex_entry.sv
// Hex operand entry: builds two operands one hex digit at a time from slide switches and two buttons.
// Optional macro HEX_ENTRY_BACKSPACE_EN turns clear into a one-digit backspace while entering.
module hex_entry #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int DIGITS          = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  digit_in,
   input  logic        key_enter_n,
   input  logic        key_clear_n,
   output logic [31:0] bus_a,
   output logic [31:0] bus_b,
   output logic [1:0]  state,
   output logic [3:0]  digit_count,
   output logic        valid
);

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      DONE    = 2'd2,
      ILLEGAL = 2'd3
   } state_t;

   localparam int              CW         = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0]      LAST_DIGIT = 4'(DIGITS - 1);
   localparam logic [31:0]     OP_MASK    = 32'hFFFF_FFFF >> (32 - 4 * DIGITS);

   // Index 0 is the enter key, index 1 the clear key.
   logic [1:0]    key_s1, key_s2, key_db, key_ev;
   logic [CW-1:0] key_cnt [2];
   logic [3:0]    digit_s1, digit_s2;
   state_t        st;

   logic enter_ev, clear_ev;
   assign enter_ev = key_ev[0];
   assign clear_ev = key_ev[1];
   assign state    = st;

   function automatic logic [31:0] shift_in(input logic [31:0] v, input logic [3:0] d);
      return {v[27:0], d} & OP_MASK;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_s1     <= 2'b11;
         key_s2     <= 2'b11;
         key_db     <= 2'b11;
         key_ev     <= 2'b00;
         key_cnt[0] <= '0;
         key_cnt[1] <= '0;
         digit_s1   <= 4'h0;
         digit_s2   <= 4'h0;
      end else begin
         key_s1   <= {key_clear_n, key_enter_n};
         key_s2   <= key_s1;
         digit_s1 <= digit_in;
         digit_s2 <= digit_s1;
         for (int k = 0; k < 2; k++) begin
            key_ev[k] <= 1'b0;
            if (key_s2[k] == key_db[k]) begin
               key_cnt[k] <= '0;
            end else if (key_cnt[k] == CNT_LAST) begin
               // Accept the new level; only a 1->0 transition is a press.
               key_db[k]  <= key_s2[k];
               key_cnt[k] <= '0;
               key_ev[k]  <= ~key_s2[k];
            end else begin
               key_cnt[k] <= key_cnt[k] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st          <= ENTER_A;
         bus_a       <= 32'h0;
         bus_b       <= 32'h0;
         digit_count <= 4'h0;
         valid       <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (st)
            ENTER_A: begin
               if (clear_ev) begin
`ifdef HEX_ENTRY_BACKSPACE_EN
                  bus_a       <= bus_a >> 4;
                  digit_count <= (digit_count == 4'h0) ? 4'h0 : digit_count - 4'h1;
`else
                  bus_a       <= 32'h0;
                  digit_count <= 4'h0;
`endif
               end else if (enter_ev) begin
                  bus_a <= shift_in(bus_a, digit_s2);
                  if (digit_count == LAST_DIGIT) begin
                     st          <= ENTER_B;
                     digit_count <= 4'h0;
                  end else begin
                     digit_count <= digit_count + 4'h1;
                  end
               end
            end
            ENTER_B: begin
               if (clear_ev) begin
`ifdef HEX_ENTRY_BACKSPACE_EN
                  bus_b       <= bus_b >> 4;
                  digit_count <= (digit_count == 4'h0) ? 4'h0 : digit_count - 4'h1;
`else
                  bus_b       <= 32'h0;
                  digit_count <= 4'h0;
`endif
               end else if (enter_ev) begin
                  bus_b <= shift_in(bus_b, digit_s2);
                  if (digit_count == LAST_DIGIT) begin
                     st          <= DONE;
                     digit_count <= 4'h0;
                     valid       <= 1'b1;
                  end else begin
                     digit_count <= digit_count + 4'h1;
                  end
               end
            end
            DONE: begin
               // Either key starts a fresh pair; the digit on the switches is not consumed.
               if (clear_ev || enter_ev) begin
                  st          <= ENTER_A;
                  bus_a       <= 32'h0;
                  bus_b       <= 32'h0;
                  digit_count <= 4'h0;
               end
            end
            default: begin
               st          <= ENTER_A;
               bus_a       <= 32'h0;
               bus_b       <= 32'h0;
               digit_count <= 4'h0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hex_entry.sv
// Self-checking bench for hex_entry with DEBOUNCE_CYCLES=4, DIGITS=8.
module tb_hex_entry;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [3:0]  digit_in = 4'h0;
   logic        key_enter_n = 1'b1;
   logic        key_clear_n = 1'b1;
   logic [31:0] bus_a, bus_b;
   logic [1:0]  state;
   logic [3:0]  digit_count;
   logic        valid;

   hex_entry #(.DEBOUNCE_CYCLES(4), .DIGITS(8)) dut (
      .clk(clk), .rst_n(rst_n), .digit_in(digit_in),
      .key_enter_n(key_enter_n), .key_clear_n(key_clear_n),
      .bus_a(bus_a), .bus_b(bus_b), .state(state),
      .digit_count(digit_count), .valid(valid)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int valid_total = 0;

   // Expected snapshot: {state, digit_count, bus_a, bus_b}
   logic [69:0] exp_q[$];
   logic [31:0] m_a = 32'h0, m_b = 32'h0;
   logic [1:0]  m_state = 2'd0;
   logic [3:0]  m_cnt = 4'h0;

   always @(negedge clk) if (valid === 1'b1) valid_total++;

   task automatic model_reset();
      m_a = 0; m_b = 0; m_state = 0; m_cnt = 0;
   endtask

   task automatic model_event(input logic is_clear, input logic [3:0] d);
      if (m_state == 2'd2) begin
         model_reset();
      end else if (is_clear) begin
`ifdef HEX_ENTRY_BACKSPACE_EN
         if (m_state == 2'd0) m_a = m_a >> 4; else m_b = m_b >> 4;
         if (m_cnt != 0) m_cnt = m_cnt - 1;
`else
         if (m_state == 2'd0) m_a = 0; else m_b = 0;
         m_cnt = 0;
`endif
      end else begin
         if (m_state == 2'd0) m_a = {m_a[27:0], d}; else m_b = {m_b[27:0], d};
         m_cnt = m_cnt + 1;
         if (m_cnt == 4'd8) begin
            m_cnt = 0;
            m_state = m_state + 1;
         end
      end
      exp_q.push_back({m_state, m_cnt, m_a, m_b});
   endtask

   // Drive a clean press of one or both keys, holding the digit steady throughout.
   task automatic press(input logic do_enter, input logic do_clear, input logic [3:0] d, input int hold);
      @(posedge clk); #1;
      digit_in = d;
      if (do_enter) key_enter_n = 1'b0;
      if (do_clear) key_clear_n = 1'b0;
      repeat (hold) @(posedge clk);
      #1;
      key_enter_n = 1'b1;
      key_clear_n = 1'b1;
      repeat (12) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      logic [70:0] obs;
      @(posedge clk); #1;
      model_event(1'b0, 4'h9);
      press(1'b1, 1'b0, 4'h9, 10);
      checks++;
      if ({state, digit_count, bus_a, bus_b} !== exp_q.pop_front()) begin
         failures++;
         $display("FAIL pre_reset_entry got a=%h cnt=%0d st=%0d", bus_a, digit_count, state);
      end
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      obs = {state, digit_count, valid, bus_a, bus_b};
      checks++;
      if (obs !== 71'h0) begin
         failures++;
         $display("FAIL async_reset got=%h want=0", obs);
      end
      model_reset();
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_operand_a();
      logic [3:0] digs [8] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8};
      logic [69:0] e;
      for (int i = 0; i < 8; i++) begin
         model_event(1'b0, digs[i]);
         press(1'b1, 1'b0, digs[i], 10);
         e = exp_q.pop_front();
         checks++;
         if ({state, digit_count, bus_a, bus_b} !== e) begin
            failures++;
            $display("FAIL opA_digit%0d got=%h want=%h", i, {state, digit_count, bus_a, bus_b}, e);
         end
      end
      checks++;
      if (bus_a !== 32'h12345678 || state !== 2'd1) begin
         failures++;
         $display("FAIL opA_final got a=%h st=%0d want a=12345678 st=1", bus_a, state);
      end
   endtask

   task automatic test_operand_b(input logic rnd);
      logic [3:0] digs [8] = '{4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h0};
      logic [69:0] e;
      int v0;
      logic [3:0] d;
      v0 = valid_total;
      for (int i = 0; i < 8; i++) begin
         d = rnd ? 4'($urandom_range(0, 15)) : digs[i];
         model_event(1'b0, d);
         press(1'b1, 1'b0, d, 10);
         e = exp_q.pop_front();
         checks++;
         if ({state, digit_count, bus_a, bus_b} !== e) begin
            failures++;
            $display("FAIL opB_digit%0d got=%h want=%h", i, {state, digit_count, bus_a, bus_b}, e);
         end
      end
      checks++;
      if ((valid_total - v0) != 1 || valid !== 1'b0) begin
         failures++;
         $display("FAIL valid_pulse got cycles=%0d now=%b want cycles=1 now=0", valid_total - v0, valid);
      end
   endtask

   task automatic test_random_a();
      logic [69:0] e;
      logic [3:0] d;
      for (int i = 0; i < 8; i++) begin
         d = 4'($urandom_range(0, 15));
         model_event(1'b0, d);
         press(1'b1, 1'b0, d, $urandom_range(8, 14));
         e = exp_q.pop_front();
         checks++;
         if ({state, digit_count, bus_a, bus_b} !== e) begin
            failures++;
            $display("FAIL randA_digit%0d got=%h want=%h", i, {state, digit_count, bus_a, bus_b}, e);
         end
      end
   endtask

   task automatic test_done_restart();
      logic [69:0] e;
      model_event(1'b0, 4'h7);
      press(1'b1, 1'b0, 4'h7, 10);
      e = exp_q.pop_front();
      checks++;
      if ({state, digit_count, bus_a, bus_b} !== e) begin
         failures++;
         $display("FAIL done_restart got=%h want=%h", {state, digit_count, bus_a, bus_b}, e);
      end
   endtask

   task automatic test_bounce();
      logic [69:0] e;
      exp_q.push_back({m_state, m_cnt, m_a, m_b});
      @(posedge clk); #1;
      digit_in = 4'h3;
      key_enter_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 key_enter_n = 1'b1;
      repeat (15) @(posedge clk);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if ({state, digit_count, bus_a, bus_b} !== e) begin
         failures++;
         $display("FAIL bounce_reject got=%h want=%h", {state, digit_count, bus_a, bus_b}, e);
      end
      model_event(1'b0, 4'h6);
      press(1'b1, 1'b0, 4'h6, 20);
      e = exp_q.pop_front();
      checks++;
      if ({state, digit_count, bus_a, bus_b} !== e) begin
         failures++;
         $display("FAIL long_hold got=%h want=%h", {state, digit_count, bus_a, bus_b}, e);
      end
   endtask

   task automatic test_clear();
      logic [3:0] digs [3] = '{4'hA, 4'hB, 4'hC};
      logic [69:0] e;
      while (m_cnt != 0) begin
         model_event(1'b1, 4'h0);
         press(1'b0, 1'b1, 4'h0, 10);
         void'(exp_q.pop_front());
      end
      for (int i = 0; i < 3; i++) begin
         model_event(1'b0, digs[i]);
         press(1'b1, 1'b0, digs[i], 10);
         void'(exp_q.pop_front());
      end
      model_event(1'b1, 4'h0);
      press(1'b0, 1'b1, 4'h0, 10);
      e = exp_q.pop_front();
      checks++;
      if ({state, digit_count, bus_a, bus_b} !== e) begin
         failures++;
         $display("FAIL clear_mid got=%h want=%h", {state, digit_count, bus_a, bus_b}, e);
      end
`ifdef HEX_ENTRY_BACKSPACE_EN
      checks++;
      if (bus_a !== 32'h000000AB || digit_count !== 4'd2) begin
         failures++;
         $display("FAIL backspace_abs got a=%h cnt=%0d want a=000000ab cnt=2", bus_a, digit_count);
      end
`else
      checks++;
      if (bus_a !== 32'h0 || digit_count !== 4'd0) begin
         failures++;
         $display("FAIL clear_abs got a=%h cnt=%0d want a=0 cnt=0", bus_a, digit_count);
      end
`endif
   endtask

   task automatic test_simultaneous();
      logic [69:0] e;
      while (m_cnt != 0) begin
         model_event(1'b1, 4'h0);
         press(1'b0, 1'b1, 4'h0, 10);
         void'(exp_q.pop_front());
      end
      model_event(1'b0, 4'h5);
      press(1'b1, 1'b0, 4'h5, 10);
      void'(exp_q.pop_front());
      checks++;
      if (bus_a !== 32'h5) begin
         failures++;
         $display("FAIL simul_setup got a=%h want a=5", bus_a);
      end
      model_event(1'b1, 4'h7);
      press(1'b1, 1'b1, 4'h7, 10);
      e = exp_q.pop_front();
      checks++;
      if ({state, digit_count, bus_a, bus_b} !== e || bus_a !== 32'h0) begin
         failures++;
         $display("FAIL simul_clear_wins got=%h want=%h", {state, digit_count, bus_a, bus_b}, e);
      end
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({state, digit_count, valid, bus_a, bus_b} !== 71'h0) begin
         failures++;
         $display("FAIL initial_reset got st=%0d cnt=%0d v=%b a=%h b=%h", state, digit_count, valid, bus_a, bus_b);
      end
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);

      test_reset();
      test_operand_a();
      test_operand_b(1'b0);
      checks++;
      if (bus_b !== 32'hFEDCBA90 || state !== 2'd2) begin
         failures++;
         $display("FAIL opB_final got b=%h st=%0d want b=fedcba90 st=2", bus_b, state);
      end
      test_done_restart();
      test_bounce();
      test_clear();
      test_simultaneous();
      while (m_state == 2'd0) begin
         test_random_a();
      end
      test_operand_b(1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
